// File: rtl/onehot_drain_encoder.sv
// Sequential one-hot/multi-hot to binary encoder: stores a request vector and drains its set-bit indices one per beat.
// Optional build macro ONEHOT_DRAIN_MSB_FIRST_EN selects highest-set-bit-first draining.
module onehot_drain_encoder #(
  parameter int WIDTH = 4,
  parameter int IDX_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_vec,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_code,
  output logic             out_last,
  output logic             busy
);

  // Handshakes: a transfer happens on a rising edge where valid & ready are both 1;
  // valid never depends on ready in the same cycle, and rst overrides any transfer.

  typedef enum logic {IDLE = 1'b0, DRAIN = 1'b1} state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] pending, pending_next;
  logic [IDX_W-1:0] sel;
  logic             single;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      pending <= '0;
    end else begin
      state   <= state_next;
      pending <= pending_next;
    end
  end

  // The last index visited by the scan wins, so scan direction sets the priority.
  always_comb begin
    sel = '0;
`ifdef ONEHOT_DRAIN_MSB_FIRST_EN
    for (int i = 0; i < WIDTH; i++) begin
      if (pending[i]) sel = i[IDX_W-1:0];
    end
`else
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (pending[i]) sel = i[IDX_W-1:0];
    end
`endif
  end

  assign single = (pending != '0) && ((pending & (pending - 1'b1)) == '0);

  always_comb begin
    state_next   = state;
    pending_next = pending;
    case (state)
      IDLE: begin
        if (in_valid && (in_vec != '0)) begin
          pending_next = in_vec;
          state_next   = DRAIN;
        end
      end
      DRAIN: begin
        if (out_ready) begin
          if (single) begin
            pending_next = '0;
            state_next   = IDLE;
          end else begin
            pending_next = pending & ~({{(WIDTH-1){1'b0}}, 1'b1} << sel);
          end
        end
      end
      default: begin
        state_next   = IDLE;
        pending_next = '0;
      end
    endcase
  end

  assign in_ready  = (state == IDLE);
  assign busy      = (state == DRAIN);
  assign out_valid = (state == DRAIN);
  assign out_code  = (state == DRAIN) ? sel : '0;
  assign out_last  = (state == DRAIN) && single;

endmodule

// File: doc/onehot_drain_encoder.md
# onehot_drain_encoder

Sequential 4-to-2 encoder: the inverse of the team's 2-to-4 decoder. It accepts a WIDTH-bit request vector over a valid/ready handshake, stores it, and emits the binary index of every set bit, one per output handshake, with the final index flagged. It sits between request-vector producers (decoder outputs, interrupt or status bits) and index consumers that handle one event at a time.

## Interface
- WIDTH, 4, number of request bits; must be a power of two, ≥ 2
- IDX_W, 2, index width; must equal log2(WIDTH)

- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  in_vec is valid
- in_ready  output  1  block can accept a vector (1 only in IDLE)
- in_vec  input  WIDTH  request vector; bit i set means index i is pending
- out_valid  output  1  out_code is valid
- out_ready  input  1  consumer accepts out_code
- out_code  output  IDX_W  binary index of the currently selected pending bit
- out_last  output  1  1 when out_code is the final pending index of the stored vector
- busy  output  1  1 in DRAIN

## Operation
- State: 1-bit FSM {IDLE, DRAIN} plus WIDTH-bit pending register.
- in_ready = (state == IDLE). busy = (state == DRAIN). out_valid = (state == DRAIN).
- IDLE, in_valid=1, in_vec≠0: pending ← in_vec, state → DRAIN.
- IDLE, in_valid=1, in_vec=0: vector consumed, produces no output, state stays IDLE.
- DRAIN: out_code = index of the selected set bit of pending. The default selection is the lowest set bit.
- DRAIN: out_last = 1 when pending has exactly one bit set.
- DRAIN, out_ready=1: clear the selected bit in pending. If out_last=1, state → IDLE and pending ← 0.
- DRAIN, out_ready=0: pending, out_code and out_last hold unchanged.
- in_valid is ignored in DRAIN. The producer must hold in_vec until in_ready is 1.
- out_code and out_last are combinational from registered pending. They do not depend on inputs in the same cycle.
- Out of DRAIN (IDLE): out_code = 0, out_last = 0.

## Timing
- Reset (rst=1 at a clock edge) sets state=IDLE and pending=0.
- After reset: in_ready=1, out_valid=0, out_code=0, out_last=0, busy=0.
- Reset asserted mid-DRAIN aborts the drain. Remaining indices are discarded and no further output is produced.
- rst has priority over every handshake in the same cycle.
- Latency, accept to first output: 1 cycle. out_valid rises in the cycle after the in_valid & in_ready edge.
- Throughput with out_ready held at 1: one index per cycle. A vector with k set bits occupies k DRAIN cycles.
- Turnaround: in_ready returns 1 in the cycle after the out_last handshake.
- There is no same-cycle accept of a new vector during the last output beat. Minimum period per nonzero vector is k+1 cycles.
- A zero vector occupies the input for 1 cycle and nothing else.
- All-ones vector (4'b1111): 4 output beats; out_last=1 only on the 4th.

## Configuration
- Macro: ONEHOT_DRAIN_MSB_FIRST_EN.
- Not defined (default): selection is the lowest set bit; indices are emitted in ascending order.
- Defined: selection is the highest set bit; indices are emitted in descending order.
- Handshake, timing, out_last semantics and reset behaviour are identical in both builds.

## Test plan
- Reset behaviour: hold rst=1 for 2 cycles, then release. Required: in_ready=1, out_valid=0, out_code=0, out_last=0, busy=0.
- Basic drain: in_vec=4'b1011 accepted, out_ready=1. Required: out_code 0, 1, 3 on 3 consecutive cycles starting 1 cycle after accept; out_last=1 only with code 3; in_ready=1 on the next cycle.
- Backpressure: in_vec=4'b0110, out_ready=0 for 3 cycles, then 1. Required: out_code=1 held stable, out_last=0 throughout the stall, then codes 1 and 2 with out_last on 2. A new in_valid during DRAIN is not accepted.
- Zero and single-bit vectors: in_vec=4'b0000 produces no out_valid and in_ready stays 1. in_vec=4'b1000 produces a single beat, code 3, out_last=1.
- Reset mid-drain: accept 4'b1111, take 1 beat (code 0), then assert rst. Required: out_valid=0 on the next cycle, in_ready=1, and codes 1–3 never appear.
- MSB-first build (ONEHOT_DRAIN_MSB_FIRST_EN defined): in_vec=4'b1011 produces codes 3, 1, 0, with out_last=1 on code 0.
